mod_buzzer_seq: RTL and testbench

MOD_BUZZER_SEQ -- requirements
Module: mod_buzzer_seq

---
 rtl/mod_buzzer_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_mod_buzzer_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_buzzer_seq.sv
// ---------------------------------------------------------------------------
// mod_buzzer_seq
//
// Beep-sequence generator for a piezo/magnetic buzzer. A trigger latches a
// tone half-period, beep length, gap length and beep count, then plays
// ON/OFF phases timed by a millisecond prescaler. The final gap is skipped.
//
// Optional feature (macro BUZ_SEQ_QUEUE_EN): a one-entry pending register.
// A trigger while busy captures the inputs (the newest wins). When DONE is
// reached, the pending sequence starts instead of returning to IDLE. An
// abort also drops the pending entry.
//
// Handshake: trig_i is a level sampled on every posedge clk_i. In IDLE it
// is accepted on the first edge it is seen high. busy_o rises on that same
// edge and stays high until the edge that enters DONE. done_o is high for
// exactly the one DONE cycle.
//
// Parameters
//   CLK_HZ       clk_i frequency in Hz (integer multiple of 1000)
//   MS_W         width of ON/OFF durations in ms
//   DIV_W        width of tone half-period in clk_i cycles
//   REP_W        width of repeat count
//   PIN_ACT_LVL  driven level of pin_o
//
// Ports
//   clk_i        clock; all logic on its rising edge
//   rst_i        asynchronous active-high reset
//   trig_i       start request
//   abort_i      cancel running sequence (ON/OFF only)
//   half_per_i   tone half-period in cycles; 0 = steady DC drive
//   on_ms_i      beep length in ms; 0 = empty sequence
//   off_ms_i     gap between beeps in ms
//   reps_i       beep count; 0 is treated as 1
//   busy_o       high while a sequence runs
//   done_o       one-cycle pulse at sequence end (normal or aborted)
//   pin_o        buzzer drive
//   dbg_state    current FSM state (0 IDLE, 1 ON, 2 OFF, 3 DONE)
// ---------------------------------------------------------------------------
module mod_buzzer_seq #(
    parameter int   CLK_HZ      = 1000000,
    parameter int   MS_W        = 12,
    parameter int   DIV_W       = 16,
    parameter int   REP_W       = 4,
    parameter logic PIN_ACT_LVL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trig_i,
    input  logic             abort_i,
    input  logic [DIV_W-1:0] half_per_i,
    input  logic [MS_W-1:0]  on_ms_i,
    input  logic [MS_W-1:0]  off_ms_i,
    input  logic [REP_W-1:0] reps_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pin_o,
    output logic [1:0]       dbg_state
);

    localparam int PRE_DIV = CLK_HZ / 1000;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  half_q;
    logic [MS_W-1:0]   on_q;
    logic [MS_W-1:0]   off_q;
    logic [REP_W-1:0]  rep_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [DIV_W-1:0]  tone_cnt;

    // Sources for the latching edge (inputs, or the pending entry on DONE).
    logic [DIV_W-1:0]  ld_half;
    logic [MS_W-1:0]   ld_on;
    logic [MS_W-1:0]   ld_off;
    logic [REP_W-1:0]  ld_reps;

    logic              ms_tick;
    logic [MS_W:0]     ms_nxt;
    logic              on_end;
    logic              off_end;
    logic              tone_wrap;

`ifdef BUZ_SEQ_QUEUE_EN
    logic              pend_vld;
    logic [DIV_W-1:0]  pend_half;
    logic [MS_W-1:0]   pend_on;
    logic [MS_W-1:0]   pend_off;
    logic [REP_W-1:0]  pend_reps;

    assign ld_half = (state == S_DONE) ? pend_half : half_per_i;
    assign ld_on   = (state == S_DONE) ? pend_on   : on_ms_i;
    assign ld_off  = (state == S_DONE) ? pend_off  : off_ms_i;
    assign ld_reps = (state == S_DONE) ? pend_reps : reps_i;

    // Newest trigger while busy overwrites the entry; abort drops it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_vld  <= 1'b0;
            pend_half <= '0;
            pend_on   <= '0;
            pend_off  <= '0;
            pend_reps <= '0;
        end else if ((state == S_ON || state == S_OFF) && abort_i) begin
            pend_vld <= 1'b0;
        end else if ((state == S_ON || state == S_OFF) && trig_i) begin
            pend_vld  <= 1'b1;
            pend_half <= half_per_i;
            pend_on   <= on_ms_i;
            pend_off  <= off_ms_i;
            pend_reps <= reps_i;
        end else if (state == S_DONE) begin
            pend_vld <= 1'b0;
        end
    end
`else
    assign ld_half = half_per_i;
    assign ld_on   = on_ms_i;
    assign ld_off  = off_ms_i;
    assign ld_reps = reps_i;
`endif

    // Phase end is compared against ms_cnt+1 in a widened sum so the largest
    // duration (all ones) completes instead of wrapping.
    assign ms_tick   = (pre_cnt == PRE_MAX);
    assign ms_nxt    = {1'b0, ms_cnt} + (MS_W+1)'(1);
    assign on_end    = ms_tick && (ms_nxt == {1'b0, on_q});
    // A zero-length gap still spends one cycle in OFF.
    assign off_end   = (off_q == '0) || (ms_tick && (ms_nxt == {1'b0, off_q}));
    assign tone_wrap = (tone_cnt == (half_q - DIV_W'(1)));

    assign dbg_state = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            pin_o    <= ~PIN_ACT_LVL;
            half_q   <= '0;
            on_q     <= '0;
            off_q    <= '0;
            rep_cnt  <= '0;
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // trig_i has priority; abort_i is not looked at here.
                    if (trig_i) begin
                        state    <= S_ON;
                        busy_o   <= 1'b1;
                        half_q   <= ld_half;
                        on_q     <= ld_on;
                        off_q    <= ld_off;
                        rep_cnt  <= (ld_reps == '0) ? REP_W'(1) : ld_reps;
                        pre_cnt  <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                        // An empty sequence never drives the buzzer.
                        pin_o    <= (ld_on == '0) ? ~PIN_ACT_LVL : PIN_ACT_LVL;
                    end
                end

                S_ON: begin
                    if (abort_i || on_q == '0 || (on_end && rep_cnt <= REP_W'(1))) begin
                        // Last beep goes straight to DONE: no trailing gap.
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pin_o  <= ~PIN_ACT_LVL;
                    end else if (on_end) begin
                        state   <= S_OFF;
                        pin_o   <= ~PIN_ACT_LVL;
                        pre_cnt <= '0;
                        ms_cnt  <= '0;
                    end else begin
                        if (ms_tick) begin
                            pre_cnt <= '0;
                            ms_cnt  <= ms_cnt + MS_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                        if (half_q != '0) begin
                            if (tone_wrap) begin
                                tone_cnt <= '0;
                                pin_o    <= ~pin_o;
                            end else begin
                                tone_cnt <= tone_cnt + DIV_W'(1);
                            end
                        end
                    end
                end

                S_OFF: begin
                    if (abort_i) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pin_o  <= ~PIN_ACT_LVL;
                    end else if (off_end) begin
                        // OFF is only entered with at least two beeps left.
                        state    <= S_ON;
                        rep_cnt  <= rep_cnt - REP_W'(1);
                        pin_o    <= PIN_ACT_LVL;
                        pre_cnt  <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                    end else if (ms_tick) begin
                        pre_cnt <= '0;
                        ms_cnt  <= ms_cnt + MS_W'(1);
                    end else begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                end

                S_DONE: begin
`ifdef BUZ_SEQ_QUEUE_EN
                    if (pend_vld) begin
                        state    <= S_ON;
                        busy_o   <= 1'b1;
                        half_q   <= ld_half;
                        on_q     <= ld_on;
                        off_q    <= ld_off;
                        rep_cnt  <= (ld_reps == '0) ? REP_W'(1) : ld_reps;
                        pre_cnt  <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                        pin_o    <= (ld_on == '0) ? ~PIN_ACT_LVL : PIN_ACT_LVL;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_buzzer_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_buzzer_seq
//
// Bench for mod_buzzer_seq at default parameters (1 MHz, active-high pin).
// For each sequence the driver pushes {busy cycles, pin-active cycles,
// pin transitions} into exp_q. The monitor accumulates those measurements
// at negedge and compares them against the popped entry on every done_o.
// ---------------------------------------------------------------------------
module tb_mod_buzzer_seq;

  localparam int W = 48;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trig_i;
  logic        abort_i;
  logic [15:0] half_per_i;
  logic [11:0] on_ms_i;
  logic [11:0] off_ms_i;
  logic [3:0]  reps_i;
  logic        busy_o;
  logic        done_o;
  logic        pin_o;
  logic [1:0]  dbg_state;

  mod_buzzer_seq dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .trig_i     (trig_i),
    .abort_i    (abort_i),
    .half_per_i (half_per_i),
    .on_ms_i    (on_ms_i),
    .off_ms_i   (off_ms_i),
    .reps_i     (reps_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pin_o      (pin_o),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [15:0] m_busy, m_act, m_tog;
  logic        m_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int b, input int a, input int t);
    return {16'(b), 16'(a), 16'(t)};
  endfunction

  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (rst_i) begin
      m_busy = 0;
      m_act  = 0;
      m_tog  = 0;
      m_prev = pin_o;
    end else begin
      if (busy_o) m_busy++;
      if (pin_o) m_act++;
      if (pin_o !== m_prev) m_tog++;
      m_prev = pin_o;
      if (done_o) begin
        n_done++;
        check("done_pin_idle", 32'(pin_o), 0);
        check("done_busy_low", 32'(busy_o), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no pulse");
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", 32'(m_busy), 32'(e[47:32]));
          check("active_cycles", 32'(m_act), 32'(e[31:16]));
          check("pin_transitions", 32'(m_tog), 32'(e[15:0]));
        end
        m_busy = 0;
        m_act  = 0;
        m_tog  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One-cycle trigger; inputs are scrambled right after the latching edge.
  task automatic start_seq(input logic [15:0] hp, input logic [11:0] on_ms,
                           input logic [11:0] off_ms, input logic [3:0] reps,
                           input logic ab);
    @(posedge clk_i);
    #1;
    half_per_i = hp;
    on_ms_i    = on_ms;
    off_ms_i   = off_ms;
    reps_i     = reps;
    abort_i    = ab;
    trig_i     = 1'b1;
    @(posedge clk_i);
    #1;
    trig_i     = 1'b0;
    abort_i    = 1'b0;
    half_per_i = 16'($urandom_range(1, 65535));
    on_ms_i    = 12'($urandom_range(1, 4095));
    off_ms_i   = 12'($urandom_range(1, 4095));
    reps_i     = 4'($urandom_range(1, 15));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    check(name, 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_before;
    rst_i      = 1'b1;
    trig_i     = 1'b0;
    abort_i    = 1'b0;
    half_per_i = '0;
    on_ms_i    = '0;
    off_ms_i   = '0;
    reps_i     = '0;
    repeat (4) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_pin", 32'(pin_o), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // abort alone in IDLE does nothing
    #1 abort_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 abort_i = 1'b0;
    check("idle_abort_ignored", 32'(busy_o), 0);

    // tone 250-cycle half-period, 3 ms, one beep
    exp_q.push_back(mk(3000, 1500, 12));
    start_seq(16'd250, 12'd3, 12'd5, 4'd1, 1'b0);
    wait_drain("drain_tone", 5000);

    // DC drive, 2 ms on / 1 ms off, three beeps, no trailing gap
    exp_q.push_back(mk(8000, 6000, 6));
    start_seq(16'd0, 12'd2, 12'd1, 4'd3, 1'b0);
    wait_drain("drain_dc3", 12000);

    // empty sequence
    exp_q.push_back(mk(1, 0, 0));
    start_seq(16'd10, 12'd0, 12'd1, 4'd3, 1'b0);
    wait_drain("drain_on0", 100);

    // abort in the middle of beep 2 of 4
    exp_q.push_back(mk(2500, 1500, 4));
    start_seq(16'd0, 12'd1, 12'd1, 4'd4, 1'b0);
    repeat (2499) @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    wait_drain("drain_abort", 100);

    // reset in the middle of ON: immediate idle, no done pulse
    start_seq(16'd0, 12'd2, 12'd1, 4'd1, 1'b0);
    repeat (500) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_done", 32'(done_o), 0);
    check("midrst_pin", 32'(pin_o), 0);
    check("midrst_state", 32'(dbg_state), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    done_before = n_done;
    repeat (2500) @(posedge clk_i);
    check("midrst_no_done", 32'(n_done), 32'(done_before));
    check("midrst_stays_idle", 32'(busy_o), 0);

    // triggers while busy: ignored, or only the newest queued
    exp_q.push_back(mk(3000, 3000, 2));
    start_seq(16'd0, 12'd3, 12'd1, 4'd1, 1'b0);
    repeat (100) @(posedge clk_i);
    start_seq(16'd0, 12'd1, 12'd1, 4'd1, 1'b0);
    repeat (100) @(posedge clk_i);
    start_seq(16'd0, 12'd2, 12'd1, 4'd1, 1'b0);
`ifdef BUZ_SEQ_QUEUE_EN
    exp_q.push_back(mk(2000, 2000, 2));
`endif
    wait_drain("drain_busy_trig", 8000);
    repeat (2500) @(posedge clk_i);
    #1;
    check("busy_trig_idle_after", 32'(busy_o), 0);

    // trig and abort together in IDLE: trig wins
    exp_q.push_back(mk(1000, 1000, 2));
    start_seq(16'd0, 12'd1, 12'd1, 4'd1, 1'b1);
    wait_drain("drain_trig_abort", 2000);

    // reps=0 behaves as one beep
    exp_q.push_back(mk(1000, 1000, 2));
    start_seq(16'd0, 12'd1, 12'd7, 4'd0, 1'b0);
    wait_drain("drain_reps0", 2000);

    // maximum repeat count runs to completion
    exp_q.push_back(mk(29000, 15000, 30));
    start_seq(16'd0, 12'd1, 12'd1, 4'd15, 1'b0);
    wait_drain("drain_reps15", 40000);

    check("queue_empty_end", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
